// File: rtl/md_pkg.sv
// Shared constants and FSM state type for the MD position loader and the force stage.
package md_pkg;

   localparam int BLOCK_SIDE     = 4;
   localparam int DENSITY_FACTOR = 10;
   localparam int FRAC_BITS      = 16;
   localparam int N              = BLOCK_SIDE * BLOCK_SIDE * BLOCK_SIDE * DENSITY_FACTOR;
   localparam int AW             = $clog2(N);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      START,
      WAIT_DONE
   } md_state_e;

endpackage

// File: rtl/md_pos_ram.sv
// Position store: one write port, one registered read port returning old data on collision.
module md_pos_ram #(
   parameter int DEPTH  = 640,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   logic [31:0] mem [DEPTH];

   // No reset on the array: contents survive reset and aborted frames.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rdata <= 32'h0;
      end else if (32'(raddr) < DEPTH) begin
         rdata <= mem[raddr];
      end else begin
         rdata <= 32'h0;
      end
   end

endmodule

// File: rtl/md_position_loader.sv
// Loads one frame of particle positions into md_pos_ram, then hands off to the force stage.
// Optional macro MD_LOADER_RANGE_CHECK_EN enables the sticky out-of-box err_range flag.
module md_position_loader
   import md_pkg::md_state_e, md_pkg::IDLE, md_pkg::LOAD, md_pkg::START, md_pkg::WAIT_DONE;
#(
   parameter int   BLOCK_SIDE     = md_pkg::BLOCK_SIDE,
   parameter int   DENSITY_FACTOR = md_pkg::DENSITY_FACTOR,
   parameter int   FRAC_BITS      = md_pkg::FRAC_BITS,
   localparam int  N              = BLOCK_SIDE * BLOCK_SIDE * BLOCK_SIDE * DENSITY_FACTOR,
   localparam int  AW             = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_data,
   input  logic          in_last,
   output logic          md_start,
   input  logic          md_done,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   output logic          busy,
   output logic [AW:0]   load_count,
   output logic          err_len,
   output logic          err_range,
   output md_state_e     state_dbg
);

   localparam int            CW       = AW + 1;
   localparam logic [CW-1:0] N_CNT    = CW'(N);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   md_state_e     state;
   logic [AW-1:0] wr_ptr;
   logic          accept;
   logic [CW-1:0] cnt_next;
   logic          end_frame;
   logic          len_bad;

   // A box edge must be representable as a 32-bit fixed-point position word.
   if ((64'(BLOCK_SIDE) << FRAC_BITS) > 64'hFFFF_FFFF) begin : g_cfg_check
      $error("BLOCK_SIDE << FRAC_BITS does not fit a 32-bit position word");
   end

   // Stream handshake: a beat transfers on any rising edge where in_valid && in_ready;
   // in_ready depends only on the registered state, and upstream holds data until it transfers.
   assign in_ready  = (state == IDLE) || (state == LOAD);
   assign busy      = (state != IDLE);
   assign state_dbg = state;
   assign accept    = in_valid && in_ready && !reset;

   assign cnt_next  = (state == IDLE) ? CNT_ONE : load_count + CNT_ONE;
   assign end_frame = in_last || (cnt_next == N_CNT);
   // Length is wrong when in_last and the N-th beat do not coincide.
   assign len_bad   = in_last ^ (cnt_next == N_CNT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         load_count <= '0;
         md_start   <= 1'b0;
         err_len    <= 1'b0;
      end else begin
         md_start <= 1'b0;
         case (state)
            IDLE, LOAD: begin
               if (accept) begin
                  load_count <= cnt_next;
                  err_len    <= ((state == IDLE) ? 1'b0 : err_len) | len_bad;
                  if (end_frame) begin
                     state    <= START;
                     wr_ptr   <= '0;
                     md_start <= 1'b1;
                  end else begin
                     state  <= LOAD;
                     wr_ptr <= wr_ptr + AW'(1);
                  end
               end
            end
            START:     state <= WAIT_DONE;
            WAIT_DONE: if (md_done) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

`ifdef MD_LOADER_RANGE_CHECK_EN
   localparam logic [31:0] RANGE_LIMIT = 32'(BLOCK_SIDE) << FRAC_BITS;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_range <= 1'b0;
      end else if (accept) begin
         err_range <= ((state == IDLE) ? 1'b0 : err_range) | (in_data >= RANGE_LIMIT);
      end
   end
`else
   assign err_range = 1'b0;
`endif

   md_pos_ram #(
      .DEPTH  (N),
      .ADDR_W (AW)
   ) u_ram (
      .clk   (clk),
      .reset (reset),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (in_data),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_md_position_loader.sv
// Self-checking bench for md_position_loader: frame loads, length errors, stalls, reset abort, reads.
module tb_md_position_loader;
   import md_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_data;
   logic            in_last;
   logic            md_start;
   logic            md_done;
   logic [AW-1:0]   rd_addr;
   logic [31:0]     rd_data;
   logic            busy;
   logic [AW:0]     load_count;
   logic            err_len;
   logic            err_range;
   md_state_e       state_dbg;

   int              checks = 0;
   int              failures = 0;
   int              start_cnt = 0;
   int              wp = 0;
   logic [31:0]     model [N];
   logic [31:0]     exp_q [$];
   logic [31:0]     extra_d;
   int              base_starts;

   md_position_loader dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .md_start   (md_start),
      .md_done    (md_done),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .load_count (load_count),
      .err_len    (err_len),
      .err_range  (err_range),
      .state_dbg  (state_dbg)
   );

   // Clock / reset
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (md_start === 1'b1) start_cnt++;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      tick();
      model[wp] = d;
      wp = (l || wp == N - 1) ? 0 : wp + 1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic done_pulse();
      md_done = 1'b1;
      tick();
      md_done = 1'b0;
   endtask

   // Scoreboard: expected read data is queued when the address is driven.
   task automatic rd_issue(input int a);
      rd_addr = AW'(a);
      exp_q.push_back((a < N) ? model[a] : 32'h0);
   endtask

   task automatic rd_pop(input string tag);
      logic [31:0] e;
      e = exp_q.pop_front();
      check(tag, rd_data, e);
   endtask

   task automatic read_check(input int a, input string tag);
      rd_issue(a);
      tick();
      rd_pop(tag);
   endtask

   initial begin
      reset    = 1'b1;
      in_valid = 1'b0;
      in_data  = 32'h0;
      in_last  = 1'b0;
      md_done  = 1'b0;
      rd_addr  = '0;
      repeat (3) tick();
      reset = 1'b0;

      check("rst_state", 32'(state_dbg), 32'(IDLE));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(load_count), 32'd0);
      check("rst_err_len", 32'(err_len), 32'd0);
      check("rst_err_range", 32'(err_range), 32'd0);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_md_start", 32'(md_start), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Full frame 0..639 with in_last on the final beat
      for (int i = 0; i < N; i++) begin
         send_beat(32'(i), i == N - 1);
         if (i == 0) begin
            check("full_state_load", 32'(state_dbg), 32'(LOAD));
            check("full_count1", 32'(load_count), 32'd1);
            check("full_busy", 32'(busy), 32'd1);
         end
      end
      check("full_md_start", 32'(md_start), 32'd1);
      check("full_count", 32'(load_count), 32'(N));
      check("full_err_len", 32'(err_len), 32'd0);
      check("full_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("full_md_start_off", 32'(md_start), 32'd0);
      check("full_state_wait", 32'(state_dbg), 32'(WAIT_DONE));
      check("full_starts", 32'(start_cnt), 32'd1);
      read_check(5, "rd_5");
      read_check(N - 1, "rd_last");
      read_check(N, "rd_oob_n");
      read_check(1023, "rd_oob_max");
      for (int k = 0; k < 4; k++) read_check(int'($urandom_range(0, N - 1)), "rd_rand");
      done_pulse();
      check("full_idle", 32'(state_dbg), 32'(IDLE));
      check("full_busy_off", 32'(busy), 32'd0);

      // Short frame: 3 beats, in_last on the third
      for (int i = 0; i < 3; i++) send_beat($urandom, i == 2);
      check("short_err_len", 32'(err_len), 32'd1);
      check("short_count", 32'(load_count), 32'd3);
      check("short_md_start", 32'(md_start), 32'd1);
      tick();
      read_check(3, "short_keep3");
      read_check(2, "short_new2");
      done_pulse();

      // Overlong frame: 640 beats without in_last, then beat 641 stalls
      rd_issue(0);
      send_beat($urandom, 1'b0);
      rd_pop("collide_old");
      check("long_err_clr", 32'(err_len), 32'd0);
      for (int i = 1; i < N; i++) send_beat($urandom, 1'b0);
      check("long_err_len", 32'(err_len), 32'd1);
      check("long_count", 32'(load_count), 32'(N));
      check("long_md_start", 32'(md_start), 32'd1);
      base_starts = start_cnt;
      extra_d  = $urandom;
      in_valid = 1'b1;
      in_data  = extra_d;
      in_last  = 1'b0;
      repeat (4) begin
         tick();
         check("long_stall", 32'(in_ready), 32'd0);
      end
      check("long_count_hold", 32'(load_count), 32'(N));
      check("long_one_start", 32'(start_cnt), 32'(base_starts + 1));
      md_done = 1'b1;
      tick();
      md_done = 1'b0;
      check("long_idle", 32'(state_dbg), 32'(IDLE));
      check("long_ready", 32'(in_ready), 32'd1);
      send_beat(extra_d, 1'b0);
      check("new_state", 32'(state_dbg), 32'(LOAD));
      check("new_count", 32'(load_count), 32'd1);
      check("new_err_clr", 32'(err_len), 32'd0);

      // Reset on beat 100 of that frame
      for (int i = 1; i < 99; i++) send_beat($urandom, 1'b0);
      check("pre_rst_count", 32'(load_count), 32'd99);
      base_starts = start_cnt;
      in_valid = 1'b1;
      in_data  = $urandom;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      wp = 0;
      check("abort_state", 32'(state_dbg), 32'(IDLE));
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_count", 32'(load_count), 32'd0);
      repeat (3) tick();
      check("abort_no_start", 32'(start_cnt), 32'(base_starts));
      read_check(0, "abort_mem0");
      read_check(50, "abort_mem50");
      read_check(200, "abort_mem200");

      // md_done ignored in LOAD, honoured in WAIT_DONE, no beats accepted while waiting
      send_beat($urandom, 1'b0);
      md_done = 1'b1;
      send_beat($urandom, 1'b0);
      md_done = 1'b0;
      check("ign_done_state", 32'(state_dbg), 32'(LOAD));
      check("ign_done_count", 32'(load_count), 32'd2);
      send_beat($urandom, 1'b1);
      extra_d  = $urandom;
      in_valid = 1'b1;
      in_data  = extra_d;
      repeat (3) begin
         tick();
         check("wait_no_accept", 32'(in_ready), 32'd0);
      end
      check("wait_count", 32'(load_count), 32'd3);
      md_done = 1'b1;
      tick();
      md_done = 1'b0;
      check("wait_to_idle", 32'(state_dbg), 32'(IDLE));
      send_beat(extra_d, 1'b0);
      check("held_accept", 32'(load_count), 32'd1);
      send_beat($urandom, 1'b1);
      tick();
      done_pulse();
      read_check(0, "held_data");

      // Range flag on a position exactly at the box edge, then just inside
      send_beat(32'h0004_0000, 1'b1);
`ifdef MD_LOADER_RANGE_CHECK_EN
      check("range_edge", 32'(err_range), 32'd1);
`else
      check("range_off", 32'(err_range), 32'd0);
`endif
      tick();
      done_pulse();
      send_beat(32'h0003_FFFF, 1'b1);
      check("range_inside", 32'(err_range), 32'd0);
      tick();
      read_check(0, "range_stored");
      done_pulse();

      check("q_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/md_position_loader.md
MD_POSITION_LOADER -- requirements
Module: md_position_loader

Interface
REQ-001 The block SHALL have parameter BLOCK_SIDE, default 4, cells per box edge.
REQ-002 The block SHALL have parameter DENSITY_FACTOR, default 10, particles per cell.
REQ-003 The block SHALL have parameter FRAC_BITS, default 16, fixed-point fraction bits of a position word.
REQ-004 The block SHALL have derived constant N = BLOCK_SIDE^3*DENSITY_FACTOR (640) and AW = clog2(N) (10).
REQ-005 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-006 The block SHALL have port reset, input, 1, reset, synchronous, active-high.
REQ-007 The block SHALL have ports in_valid, in_ready, in_data[31:0] and in_last: input, output, input and input, a position stream with valid/ready handshake.
REQ-008 The block SHALL have ports md_start (output, 1) and md_done (input, 1), the handshake to the downstream force stage.
REQ-009 The block SHALL have ports rd_addr (input, AW) and rd_data (output, 32), the read port used by the force stage.
REQ-010 The block SHALL have ports busy (output, 1), load_count (output, AW+1), err_len (output, 1) and err_range (output, 1), as status outputs.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, START and WAIT_DONE.
REQ-012 The block SHALL hold in_ready=1 in IDLE and LOAD, and 0 in START and WAIT_DONE.
REQ-013 A beat SHALL be accepted when in_valid&&in_ready. It writes mem[wr_ptr] and increments wr_ptr and load_count.
REQ-014 On the first accepted beat, IDLE SHALL go to LOAD and SHALL clear err_len, err_range and load_count. That beat counts as 1.
REQ-015 A beat with in_last=1, or the N-th accepted beat, SHALL end the frame. Next state is START and wr_ptr returns to 0.
REQ-016 If in_last arrives with load_count<N, the block SHALL set sticky err_len. Unwritten entries keep their old contents.
REQ-017 If the N-th beat has in_last=0, the block SHALL set err_len. in_ready is already low the next cycle, so surplus beats stall upstream.
REQ-018 In START, md_start SHALL be 1 for exactly one cycle, followed by WAIT_DONE.
REQ-019 WAIT_DONE SHALL go to IDLE on the first cycle md_done=1. md_done in any other state SHALL be ignored.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 The read port SHALL register rd_data = mem[rd_addr] with 1-cycle latency in every state.
REQ-022 On a same-cycle write and read to the same address, rd_data SHALL return the old data.
REQ-023 An rd_addr >= N SHALL return 0.
REQ-024 in_data SHALL be stored unmodified. No arithmetic is done on it.

Reset
REQ-025 Reset SHALL force state IDLE, wr_ptr=0, load_count=0, md_start=0, busy=0, err_len=0, err_range=0 and rd_data=0.
REQ-026 Reset SHALL NOT clear mem.
REQ-027 Reset during LOAD or WAIT_DONE SHALL abort the frame. No md_start is issued for it.

Configuration
REQ-028 With macro MD_LOADER_RANGE_CHECK_EN defined, each accepted beat with unsigned in_data >= (BLOCK_SIDE << FRAC_BITS) SHALL set sticky err_range. The data is still stored.
REQ-029 Without MD_LOADER_RANGE_CHECK_EN, err_range SHALL be tied to 0 and no compare logic SHALL exist.

Structure
REQ-030 A package md_pkg SHALL hold BLOCK_SIDE, DENSITY_FACTOR, FRAC_BITS, N, AW and the FSM state enum. The force stage shares it.
REQ-031 Storage SHALL be one sub-module md_pos_ram: single write port, single registered read port, N x 32, read-old-data on collision.

Verification
REQ-032 Stream 640 beats 0..639 with in_last on beat 639 -> md_start pulses once 1 cycle after the last beat. err_len=0 and load_count=640. rd_addr=5 gives rd_data=5 one cycle later.
REQ-033 Stream 3 beats with in_last on the third -> err_len=1 and load_count=3. mem[3] keeps its previous value.
REQ-034 Stream 641 beats with no in_last -> err_len=1 after beat 640. in_ready=0 stalls beat 641 until md_done, then it opens a new frame.
REQ-035 Assert reset on beat 100 of a load -> next cycle state IDLE, busy=0, load_count=0. No md_start follows.
REQ-036 With MD_LOADER_RANGE_CHECK_EN, send a beat of 0x0004_0000 -> err_range=1. A beat of 0x0003_FFFF alone -> err_range=0.
REQ-037 Pulse md_done during LOAD, then in WAIT_DONE, and hold in_valid=1 throughout -> only the WAIT_DONE pulse returns to IDLE. No beats are accepted outside IDLE/LOAD.
